// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Slot fields are sized for the widest supported config.
package hazard_pkg;

  localparam int AW_MAX = 8;
  localparam int TW_MAX = 4;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  // Narrowed to TNEW_W bits by the user.
  localparam logic [TW_MAX-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic [AW_MAX-1:0] rs;
    logic [AW_MAX-1:0] rt;
    logic [AW_MAX-1:0] dst;
    logic              we;
    logic [TW_MAX-1:0] tnew;
    logic              md;
    logic              div;
  } slot_t;

  localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bundle: D operand/dest info in, stall and forward selects out.
// master = pipeline control, slave = scoreboard. HAZARD_PERF_EN adds perf counters.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
);
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TNEW_W-1:0] d_rs_tuse;
  logic [TNEW_W-1:0] d_rt_tuse;
  logic [REG_AW-1:0] d_dst;
  logic              d_we;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              stall;
  logic [1:0]        fwd_d_rs_sel;
  logic [1:0]        fwd_d_rt_sel;
  logic [1:0]        fwd_e_rs_sel;
  logic [1:0]        fwd_e_rt_sel;
  logic              md_start;
  logic              md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_data_stall;
  logic [31:0]       perf_md_stall;

  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst,
    output d_we, d_tnew, d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs_sel, fwd_d_rt_sel,
    input  fwd_e_rs_sel, fwd_e_rt_sel, md_start, md_busy,
    input  perf_data_stall, perf_md_stall
  );
  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst,
    input  d_we, d_tnew, d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs_sel, fwd_d_rt_sel,
    output fwd_e_rs_sel, fwd_e_rt_sel, md_start, md_busy,
    output perf_data_stall, perf_md_stall
  );
`else
  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst,
    output d_we, d_tnew, d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs_sel, fwd_d_rt_sel,
    input  fwd_e_rs_sel, fwd_e_rt_sel, md_start, md_busy
  );
  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst,
    input  d_we, d_tnew, d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs_sel, fwd_d_rt_sel,
    output fwd_e_rs_sel, fwd_e_rt_sel, md_start, md_busy
  );
`endif
endinterface

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// HI/LO busy counter: loads mult/div latency when an md op leaves E.
// Ports: clk, reset (sync, high), start/div from E slot, busy out.
module md_busy_counter #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);
  localparam int MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit holding E/M/W dest slots with Tnew countdown; drives stall and forwards.
// Ports: clk, reset (sync, high), hz (slave). HAZARD_PERF_EN adds stall counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);
  typedef logic [AW_MAX-1:0] addr_t;
  typedef logic [TW_MAX-1:0] tn_t;

  localparam tn_t NONE = tn_t'(TUSE_NONE[TNEW_W-1:0]);

  slot_t e_q, m_q, w_q;
  slot_t d_slot, m_nxt;
  logic  busy, data_stall, md_stall, stall;
  logic  unused_slot_bits;

  function automatic logic match(slot_t s, addr_t a);
    return s.we && (s.dst == a) && (a != '0);
  endfunction

  function automatic logic hold(slot_t e, slot_t m,
                                addr_t a, tn_t u);
    return (u != NONE) &&
           ((match(e, a) && (e.tnew > u)) ||
            (match(m, a) && (m.tnew > u)));
  endfunction

  function automatic logic [1:0] fwd(slot_t m, slot_t w,
                                     addr_t a);
    if (match(m, a) && (m.tnew == '0)) return FWD_M;
    if (match(w, a)) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    d_slot      = BUBBLE;
    d_slot.rs   = addr_t'(hz.d_rs);
    d_slot.rt   = addr_t'(hz.d_rt);
    d_slot.dst  = addr_t'(hz.d_dst);
    d_slot.we   = hz.d_we;
    d_slot.tnew = tn_t'(hz.d_tnew);
    d_slot.md   = hz.d_md_start;
    d_slot.div  = hz.d_md_div;
  end

  // Tnew counts down one per stage, floored at 0.
  always_comb begin
    m_nxt = e_q;
    if (e_q.tnew != '0) m_nxt.tnew = e_q.tnew - tn_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      w_q <= m_q;
      m_q <= m_nxt;
      e_q <= stall ? BUBBLE : d_slot;
    end
  end

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .start (e_q.md),
    .div   (e_q.div),
    .busy  (busy)
  );

  always_comb begin
    data_stall =
      hold(e_q, m_q, addr_t'(hz.d_rs), tn_t'(hz.d_rs_tuse)) |
      hold(e_q, m_q, addr_t'(hz.d_rt), tn_t'(hz.d_rt_tuse));
    md_stall = hz.d_md_use & (e_q.md | busy);
    stall    = data_stall | md_stall;
  end

  assign hz.stall        = stall;
  assign hz.fwd_d_rs_sel = fwd(m_q, w_q, addr_t'(hz.d_rs));
  assign hz.fwd_d_rt_sel = fwd(m_q, w_q, addr_t'(hz.d_rt));
  assign hz.fwd_e_rs_sel = fwd(m_q, w_q, e_q.rs);
  assign hz.fwd_e_rt_sel = fwd(m_q, w_q, e_q.rt);
  assign hz.md_start     = e_q.md;
  assign hz.md_busy      = busy;

  // M/W only need dst/we (and M tnew); the rest rides along.
  assign unused_slot_bits = ^{m_q.rs, m_q.rt, m_q.md, m_q.div,
                              w_q.rs, w_q.rt, w_q.tnew,
                              w_q.md, w_q.div};

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_d_q, perf_m_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_d_q <= '0;
      perf_m_q <= '0;
    end else begin
      if (data_stall) perf_d_q <= perf_d_q + 32'd1;
      if (md_stall)   perf_m_q <= perf_m_q + 32'd1;
    end
  end

  assign hz.perf_data_stall = perf_d_q;
  assign hz.perf_md_stall   = perf_m_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: cycle-indexed instruction history model plus directed literals.
// Randomised D-stage traffic with occasional resets.
module tb_hazard_scoreboard;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int NCYC     = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .TNEW_W(2)) hz();

  hazard_scoreboard #(
    .REG_AW(5), .TNEW_W(2),
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    bit we, md, dv;
    int rs, rt, dst, tnew;
  } ins_t;

  // ent[n] = instruction that occupies E during cycle n.
  ins_t ent [NCYC];
  int   cyc = 0;
  int   mark = 0;
  int   md_c = -1000;
  int   md_lat = 0;
  bit   last_stall = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
`ifdef HAZARD_PERF_EN
  int unsigned pd = 0, pm = 0;
`endif

  function automatic ins_t at(int idx);
    ins_t b;
    b = '{default: 0};
    if (idx <= mark || idx < 0) return b;
    return ent[idx];
  endfunction

  function automatic bit mt(ins_t s, int a);
    return s.we && s.dst == a && a != 0;
  endfunction

  function automatic int eff(ins_t s, int age);
    return (s.tnew > age) ? s.tnew - age : 0;
  endfunction

  function automatic bit opnd_stall(int n, int a, int u);
    ins_t e, m;
    e = at(n);
    m = at(n - 1);
    if (u == 3) return 1'b0;
    return (mt(e, a) && eff(e, 0) > u) ||
           (mt(m, a) && eff(m, 1) > u);
  endfunction

  function automatic bit busy_at(int n);
    return n > md_c && n <= md_c + md_lat;
  endfunction

  function automatic bit dstall_at(int n);
    return opnd_stall(n, int'(hz.d_rs), int'(hz.d_rs_tuse)) ||
           opnd_stall(n, int'(hz.d_rt), int'(hz.d_rt_tuse));
  endfunction

  function automatic bit mstall_at(int n);
    ins_t e;
    e = at(n);
    return hz.d_md_use && (e.md || busy_at(n));
  endfunction

  function automatic int sel_at(int n, int a);
    ins_t m, w;
    m = at(n - 1);
    w = at(n - 2);
    if (mt(m, a) && eff(m, 1) == 0) return 2;
    if (mt(w, a)) return 1;
    return 0;
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Model update at each edge.
  initial begin
    ins_t e, d;
    bit st;
    forever begin
      @(posedge clk);
      if (reset) begin
        mark = cyc + 1;
        md_c = -1000;
        last_stall = 1'b0;
`ifdef HAZARD_PERF_EN
        pd = 0;
        pm = 0;
`endif
      end else begin
        st = dstall_at(cyc) || mstall_at(cyc);
`ifdef HAZARD_PERF_EN
        if (dstall_at(cyc)) pd++;
        if (mstall_at(cyc)) pm++;
`endif
        e = at(cyc);
        if (e.md) begin
          md_c = cyc;
          md_lat = e.dv ? DIV_LAT : MULT_LAT;
        end
        d = '{default: 0};
        if (!st) begin
          d.we = hz.d_we;
          d.md = hz.d_md_start;
          d.dv = hz.d_md_div;
          d.rs = int'(hz.d_rs);
          d.rt = int'(hz.d_rt);
          d.dst = int'(hz.d_dst);
          d.tnew = int'(hz.d_tnew);
        end
        if (cyc + 1 >= NCYC) begin
          $display("FAIL history_overflow cycle %0d", cyc);
          $fatal(1);
        end
        ent[cyc + 1] = d;
        last_stall = st;
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    ins_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = at(cyc);
        chk("stall", 32'(hz.stall),
            32'(dstall_at(cyc) || mstall_at(cyc)));
        chk("fwd_d_rs", 32'(hz.fwd_d_rs_sel),
            32'(sel_at(cyc, int'(hz.d_rs))));
        chk("fwd_d_rt", 32'(hz.fwd_d_rt_sel),
            32'(sel_at(cyc, int'(hz.d_rt))));
        chk("fwd_e_rs", 32'(hz.fwd_e_rs_sel),
            32'(sel_at(cyc, e.rs)));
        chk("fwd_e_rt", 32'(hz.fwd_e_rt_sel),
            32'(sel_at(cyc, e.rt)));
        chk("md_start", 32'(hz.md_start), 32'(e.md));
        chk("md_busy", 32'(hz.md_busy), 32'(busy_at(cyc)));
`ifdef HAZARD_PERF_EN
        chk("perf_data", hz.perf_data_stall, pd);
        chk("perf_md", hz.perf_md_stall, pm);
`endif
      end
    end
  end

  task automatic set_d(int rs, int rsu, int rt, int rtu,
                       int dst, bit we, int tn,
                       bit ms, bit dv, bit mu);
    hz.d_rs = 5'(rs);
    hz.d_rs_tuse = 2'(rsu);
    hz.d_rt = 5'(rt);
    hz.d_rt_tuse = 2'(rtu);
    hz.d_dst = 5'(dst);
    hz.d_we = we;
    hz.d_tnew = 2'(tn);
    hz.d_md_start = ms;
    hz.d_md_div = dv;
    hz.d_md_use = mu;
  endtask

  task automatic nop();
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic md_run(string nm, bit dv, int exp_len);
    int n;
    set_d(0, 3, 0, 3, 0, 0, 0, 1, dv, 1);
    @(negedge clk);
    chk({nm, "_start_pre"}, 32'(hz.md_start), 32'd0);
    step();
    set_d(0, 3, 0, 3, 6, 1, 1, 0, 0, 1);
    @(negedge clk);
    chk({nm, "_start"}, 32'(hz.md_start), 32'd1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (!hz.stall) break;
      n++;
    end
    chk({nm, "_stall_len"}, 32'(n), 32'(exp_len));
    nop();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    nop();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(hz.stall), 32'd0);
    chk("rst_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_start", 32'(hz.md_start), 32'd0);
    chk("rst_e_rs", 32'(hz.fwd_e_rs_sel), 32'd0);
    step();

    // lw $1 (tnew 2) then add reading $1 at tuse 1
    set_d(5, 1, 0, 3, 1, 1, 2, 0, 0, 0);
    @(negedge clk);
    chk("lw_nostall", 32'(hz.stall), 32'd0);
    step();
    set_d(1, 1, 2, 1, 4, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("lu_stall", 32'(hz.stall), 32'd1);
    step();
    @(negedge clk);
    chk("lu_release", 32'(hz.stall), 32'd0);
    step();
    nop();
    @(negedge clk);
    chk("lu_fwd_e_rs", 32'(hz.fwd_e_rs_sel), 32'd1);
`ifdef HAZARD_PERF_EN
    chk("lu_perf_data", hz.perf_data_stall, 32'd1);
    chk("lu_perf_md", hz.perf_md_stall, 32'd0);
`endif
    step();

    // addu $2 then beq on $2 at tuse 0
    set_d(0, 3, 0, 3, 2, 1, 1, 0, 0, 0);
    step();
    set_d(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("beq_stall", 32'(hz.stall), 32'd1);
    step();
    @(negedge clk);
    chk("beq_release", 32'(hz.stall), 32'd0);
    chk("beq_fwd_d_rs", 32'(hz.fwd_d_rs_sel), 32'd2);
    step();

    // ori $3 two ahead, then with $0 as dest
    for (int k = 0; k < 2; k++) begin
      set_d(0, 3, 0, 3, (k == 0) ? 3 : 0, 1, 1, 0, 0, 0);
      step();
      nop();
      step();
      step();
      set_d((k == 0) ? 3 : 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("ori_stall", 32'(hz.stall), 32'd0);
      chk("ori_fwd_d_rs", 32'(hz.fwd_d_rs_sel),
          (k == 0) ? 32'd1 : 32'd0);
      step();
    end

    // $5 written by both M and W: M wins
    set_d(0, 3, 0, 3, 5, 1, 1, 0, 0, 0);
    step();
    step();
    nop();
    step();
    set_d(0, 3, 5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("prio_fwd_d_rt", 32'(hz.fwd_d_rt_sel), 32'd2);
    step();
    nop();
    step();
    step();

    md_run("div", 1'b1, DIV_LAT + 1);
    md_run("mult", 1'b0, MULT_LAT + 1);

    // reset while the busy counter holds 4
    set_d(0, 3, 0, 3, 0, 0, 0, 1, 0, 1);
    step();
    set_d(0, 3, 0, 3, 6, 1, 1, 0, 0, 1);
    step();
    step();
    @(negedge clk);
    chk("mid_busy", 32'(hz.md_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_busy", 32'(hz.md_busy), 32'd0);
    chk("rmid_stall", 32'(hz.stall), 32'd0);
    chk("rmid_d_rs", 32'(hz.fwd_d_rs_sel), 32'd0);
    chk("rmid_d_rt", 32'(hz.fwd_d_rt_sel), 32'd0);
    chk("rmid_e_rs", 32'(hz.fwd_e_rs_sel), 32'd0);
    chk("rmid_e_rt", 32'(hz.fwd_e_rt_sel), 32'd0);
    nop();
    step();

    // randomised traffic; D held while stalled
    for (int i = 0; i < 2000; i++) begin
      if (!last_stall) begin
        bit ms;
        ms = ($urandom_range(0, 15) == 0);
        set_d($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), ms,
              1'($urandom_range(0, 1)),
              ms | ($urandom_range(0, 7) == 0));
      end
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    step();
    step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
